udp_rx_portmux: RTL and testbench

UDP_RX_PORTMUX -- requirements
Module: udp_rx_portmux

---
 rtl/udp_rx_portmux_pkg.sv | 29 ++
 rtl/udp_rx_portmux_port_table.sv | 62 ++++++
 rtl/udp_rx_portmux.sv | 175 +++++++++++++++++
 tb/tb_udp_rx_portmux.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_rx_portmux_pkg.sv
// udp_rx_portmux_pkg
//   Constants and types shared by the UDP receive port demultiplexer:
//   protocol number, UDP header length, input metadata bit positions,
//   receive FSM state encoding and the header verdict type.
package udp_rx_portmux_pkg;

    localparam logic [7:0]  IP_PROTO_UDP = 8'd17;
    localparam logic [15:0] UDP_HDR_LEN  = 16'd8;

    // Bit positions inside s_axis_ip_user
    localparam int unsigned USER_IPLEN_HI = 55;
    localparam int unsigned USER_IPLEN_LO = 40;
    localparam int unsigned USER_PROTO_HI = 36;
    localparam int unsigned USER_PROTO_LO = 29;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } rx_state_t;

    typedef enum logic [1:0] {
        VERDICT_OK    = 2'd0,
        VERDICT_PROTO = 2'd1,
        VERDICT_LEN   = 2'd2,
        VERDICT_PORT  = 2'd3
    } verdict_t;

endpackage

// File: rtl/udp_rx_portmux_port_table.sv
// udp_port_table
//   Listening-port table with a single write port and a combinational
//   lookup. Entry 0 resets to {P_DEFAULT_PORT, enabled}; all other entries
//   reset disabled. Writes to indices >= P_PORT_NUM are ignored. When
//   several enabled entries match, the lowest index is reported.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_wr_en          write strobe
//   i_wr_idx         entry index (4 bits)
//   i_wr_num         UDP port number to store
//   i_wr_ena         entry enable to store
//   i_lookup_port    port number to match
//   o_hit            an enabled entry matched
//   o_idx            index of the lowest matching entry
module udp_port_table #(
    parameter int unsigned P_PORT_NUM     = 4,
    parameter logic [15:0] P_DEFAULT_PORT = 16'h0808
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_wr_en,
    input  logic [3:0]  i_wr_idx,
    input  logic [15:0] i_wr_num,
    input  logic        i_wr_ena,
    input  logic [15:0] i_lookup_port,
    output logic        o_hit,
    output logic [3:0]  o_idx
);

    logic [15:0] port_num [P_PORT_NUM];
    logic        port_en  [P_PORT_NUM];

    // Per-entry index compare makes out-of-range writes fall through naturally.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < P_PORT_NUM; i++) begin
                port_num[i] <= P_DEFAULT_PORT;
                port_en[i]  <= (i == 0);
            end
        end else begin
            for (int unsigned i = 0; i < P_PORT_NUM; i++) begin
                if (i_wr_en && (i_wr_idx == 4'(i))) begin
                    port_num[i] <= i_wr_num;
                    port_en[i]  <= i_wr_ena;
                end
            end
        end
    end

    // Scan from the highest index down so the lowest match is the last write.
    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        for (int unsigned k = 0; k < P_PORT_NUM; k++) begin
            if (port_en[P_PORT_NUM-1-k] && (port_num[P_PORT_NUM-1-k] == i_lookup_port)) begin
                o_hit = 1'b1;
                o_idx = 4'(P_PORT_NUM-1-k);
            end
        end
    end

endmodule

// File: rtl/udp_rx_portmux.sv
// udp_rx_portmux
//   Receives IP payload beats, classifies the UDP header beat against a
//   listening-port table and forwards the UDP payload with a fixed two-cycle
//   latency. Non-UDP, length-error and port-miss datagrams are dropped and
//   counted; counters saturate.
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_port_wr_*           port-table write (strobe, index, number, enable)
//   s_axis_ip_*           input stream (data, user metadata, keep, last, valid)
//   m_axis_user_*         output payload stream (data, user, keep, last, valid)
//   o_cnt_*               accepted / protocol / port / length drop counters
module udp_rx_portmux
    import udp_rx_portmux_pkg::*;
#(
    parameter int unsigned P_PORT_NUM     = 4,
    parameter logic [15:0] P_DEFAULT_PORT = 16'h0808,
    parameter int unsigned P_CNT_W        = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_port_wr_en,
    input  logic [3:0]         i_port_wr_idx,
    input  logic [15:0]        i_port_wr_num,
    input  logic               i_port_wr_ena,
    input  logic [63:0]        s_axis_ip_data,
    input  logic [55:0]        s_axis_ip_user,
    input  logic [7:0]         s_axis_ip_keep,
    input  logic               s_axis_ip_last,
    input  logic               s_axis_ip_valid,
    output logic [63:0]        m_axis_user_data,
    output logic [31:0]        m_axis_user_user,
    output logic [7:0]         m_axis_user_keep,
    output logic               m_axis_user_last,
    output logic               m_axis_user_valid,
    output logic [P_CNT_W-1:0] o_cnt_ok,
    output logic [P_CNT_W-1:0] o_cnt_drop_proto,
    output logic [P_CNT_W-1:0] o_cnt_drop_port,
    output logic [P_CNT_W-1:0] o_cnt_drop_len
);

    localparam logic [P_CNT_W-1:0] CNT_ONE = {{(P_CNT_W-1){1'b0}}, 1'b1};

    rx_state_t   state;
    rx_state_t   st_eff;
    logic        resync;
    verdict_t    verdict;
    logic        tbl_hit;
    logic [3:0]  tbl_idx;
    logic [15:0] hdr_dst;
    logic [15:0] hdr_udp_len;
    logic [15:0] hdr_ip_len;
    logic [7:0]  hdr_proto;
    logic [31:0] hdr_user;

    logic        s1_valid;
    logic [63:0] s1_data;
    logic [7:0]  s1_keep;
    logic        s1_last;
    logic [31:0] s1_user;

    logic        unused_user_bits;

    assign hdr_dst     = s_axis_ip_data[47:32];
    assign hdr_udp_len = s_axis_ip_data[31:16];
    assign hdr_ip_len  = s_axis_ip_user[USER_IPLEN_HI:USER_IPLEN_LO];
    assign hdr_proto   = s_axis_ip_user[USER_PROTO_HI:USER_PROTO_LO];
    assign unused_user_bits = ^{s_axis_ip_user[39:37], s_axis_ip_user[28:0]};

    udp_port_table #(
        .P_PORT_NUM     (P_PORT_NUM),
        .P_DEFAULT_PORT (P_DEFAULT_PORT)
    ) u_port_table (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_wr_en       (i_port_wr_en),
        .i_wr_idx      (i_port_wr_idx),
        .i_wr_num      (i_port_wr_num),
        .i_wr_ena      (i_port_wr_ena),
        .i_lookup_port (hdr_dst),
        .o_hit         (tbl_hit),
        .o_idx         (tbl_idx)
    );

    // First cycle after reset: a valid non-last beat is mid-packet, so
    // treat it as if we were already dropping that packet.
    always_comb begin
        st_eff = state;
        if (resync) begin
            st_eff = (s_axis_ip_valid && !s_axis_ip_last) ? ST_DROP : ST_IDLE;
        end
    end

    always_comb begin
        verdict = VERDICT_OK;
        if (hdr_proto != IP_PROTO_UDP) begin
            verdict = VERDICT_PROTO;
        end else if ((hdr_udp_len < UDP_HDR_LEN) || (hdr_udp_len != hdr_ip_len)) begin
            verdict = VERDICT_LEN;
        end else if (!tbl_hit) begin
            verdict = VERDICT_PORT;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state             <= ST_IDLE;
            resync            <= 1'b1;
            hdr_user          <= '0;
            s1_valid          <= 1'b0;
            s1_data           <= '0;
            s1_keep           <= '1;
            s1_last           <= 1'b0;
            s1_user           <= '0;
            m_axis_user_valid <= 1'b0;
            m_axis_user_data  <= '0;
            m_axis_user_keep  <= '1;
            m_axis_user_last  <= 1'b0;
            m_axis_user_user  <= '0;
            o_cnt_ok          <= '0;
            o_cnt_drop_proto  <= '0;
            o_cnt_drop_port   <= '0;
            o_cnt_drop_len    <= '0;
        end else begin
            resync   <= 1'b0;
            s1_valid <= 1'b0;

            case (st_eff)
                ST_IDLE: begin
                    state <= ST_IDLE;
                    if (s_axis_ip_valid) begin
                        case (verdict)
                            VERDICT_OK:    if (o_cnt_ok != '1)         o_cnt_ok         <= o_cnt_ok + CNT_ONE;
                            VERDICT_PROTO: if (o_cnt_drop_proto != '1) o_cnt_drop_proto <= o_cnt_drop_proto + CNT_ONE;
                            VERDICT_LEN:   if (o_cnt_drop_len != '1)   o_cnt_drop_len   <= o_cnt_drop_len + CNT_ONE;
                            default:       if (o_cnt_drop_port != '1)  o_cnt_drop_port  <= o_cnt_drop_port + CNT_ONE;
                        endcase
                        if (verdict == VERDICT_OK) begin
                            hdr_user <= {4'h0, tbl_idx, 8'h00, hdr_udp_len - UDP_HDR_LEN};
                        end
                        if (!s_axis_ip_last) begin
                            state <= (verdict == VERDICT_OK) ? ST_FWD : ST_DROP;
                        end
                    end
                end
                ST_FWD: begin
                    state <= ST_FWD;
                    if (s_axis_ip_valid) begin
                        s1_valid <= 1'b1;
                        s1_data  <= s_axis_ip_data;
                        s1_keep  <= s_axis_ip_last ? s_axis_ip_keep : 8'hFF;
                        s1_last  <= s_axis_ip_last;
                        s1_user  <= hdr_user;
                        if (s_axis_ip_last) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= (s_axis_ip_valid && s_axis_ip_last) ? ST_IDLE : ST_DROP;
                end
            endcase

            // User field travels with each beat so a following header cannot
            // change it while the previous packet is still in the pipeline.
            m_axis_user_valid <= s1_valid;
            if (s1_valid) begin
                m_axis_user_data <= s1_data;
                m_axis_user_keep <= s1_keep;
                m_axis_user_last <= s1_last;
                m_axis_user_user <= s1_user;
            end
        end
    end

endmodule

// File: tb/tb_udp_rx_portmux.sv
module tb_udp_rx_portmux;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_idx = '0;
    logic [15:0] wr_num = '0;
    logic        wr_ena = 1'b0;
    logic [63:0] in_data = '0;
    logic [55:0] in_user = '0;
    logic [7:0]  in_keep = '0;
    logic        in_last = 1'b0;
    logic        in_valid = 1'b0;

    logic [63:0] m_data;
    logic [31:0] m_user;
    logic [7:0]  m_keep;
    logic        m_last;
    logic        m_valid;
    logic [31:0] cnt_ok, cnt_proto, cnt_port, cnt_len;

    logic [63:0] s_data;
    logic [31:0] s_user;
    logic [7:0]  s_keep;
    logic        s_last;
    logic        s_valid;
    logic [3:0]  sat_ok, sat_proto, sat_port, sat_len;

    udp_rx_portmux dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_port_wr_en(wr_en), .i_port_wr_idx(wr_idx), .i_port_wr_num(wr_num), .i_port_wr_ena(wr_ena),
        .s_axis_ip_data(in_data), .s_axis_ip_user(in_user), .s_axis_ip_keep(in_keep),
        .s_axis_ip_last(in_last), .s_axis_ip_valid(in_valid),
        .m_axis_user_data(m_data), .m_axis_user_user(m_user), .m_axis_user_keep(m_keep),
        .m_axis_user_last(m_last), .m_axis_user_valid(m_valid),
        .o_cnt_ok(cnt_ok), .o_cnt_drop_proto(cnt_proto), .o_cnt_drop_port(cnt_port), .o_cnt_drop_len(cnt_len)
    );

    // Narrow-counter instance on the same stream, used to observe saturation.
    udp_rx_portmux #(.P_CNT_W(4)) dut_sat (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_port_wr_en(wr_en), .i_port_wr_idx(wr_idx), .i_port_wr_num(wr_num), .i_port_wr_ena(wr_ena),
        .s_axis_ip_data(in_data), .s_axis_ip_user(in_user), .s_axis_ip_keep(in_keep),
        .s_axis_ip_last(in_last), .s_axis_ip_valid(in_valid),
        .m_axis_user_data(s_data), .m_axis_user_user(s_user), .m_axis_user_keep(s_keep),
        .m_axis_user_last(s_last), .m_axis_user_valid(s_valid),
        .o_cnt_ok(sat_ok), .o_cnt_drop_proto(sat_proto), .o_cnt_drop_port(sat_port), .o_cnt_drop_len(sat_len)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Reference model: port table, counters, expected output beats.
    typedef struct {
        int unsigned cyc;
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [31:0] user;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [15:0] mdl_num [4];
    logic        mdl_en  [4];
    int unsigned m_ok, m_proto, m_port, m_len;
    int unsigned out_beats = 0;
    logic [31:0] mon_last_user = '0;
    logic        mon_en = 1'b0;

    logic        hw_en = 1'b0;
    logic [3:0]  hw_idx = '0;
    logic [15:0] hw_num = '0;
    logic        hw_ena = 1'b0;

    function automatic logic [3:0] sat4(input int unsigned v);
        return (v > 15) ? 4'hF : 4'(v);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mdl_num[i] = 16'h0808;
            mdl_en[i]  = (i == 0);
        end
        m_ok = 0; m_proto = 0; m_port = 0; m_len = 0;
        exp_q.delete();
    endtask

    // 0 ok, 1 proto, 2 len, 3 port
    function automatic int model_eval(input logic [7:0] proto, input logic [15:0] ulen,
                                      input logic [15:0] iplen, input logic [15:0] dst,
                                      output int idx);
        idx = -1;
        if (proto != 8'd17) return 1;
        if (ulen < 16'd8 || ulen != iplen) return 2;
        for (int i = 0; i < 4; i++)
            if (idx < 0 && mdl_en[i] && mdl_num[i] == dst) idx = i;
        return (idx >= 0) ? 0 : 3;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++; errors++;
                $display("FAIL missing_beat: got no output beat, want beat at cycle %0d", exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            checks++;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                mon_e = exp_q.pop_front();
                if (m_valid !== 1'b1 || m_data !== mon_e.data || m_keep !== mon_e.keep ||
                    m_last !== mon_e.last || m_user !== mon_e.user) begin
                    errors++;
                    $display("FAIL out_beat cyc %0d: got v=%b d=%h k=%h l=%b u=%h, want v=1 d=%h k=%h l=%b u=%h",
                             cyc, m_valid, m_data, m_keep, m_last, m_user,
                             mon_e.data, mon_e.keep, mon_e.last, mon_e.user);
                end
                out_beats++;
                mon_last_user = m_user;
            end else if (m_valid !== 1'b0) begin
                errors++;
                $display("FAIL spurious_valid cyc %0d: got valid=%b last=%b, want valid=0", cyc, m_valid, m_last);
            end
        end
    end

    task automatic write_entry(input logic [3:0] idx, input logic [15:0] num, input logic ena);
        @(negedge clk);
        in_valid = 1'b0;
        wr_en = 1'b1; wr_idx = idx; wr_num = num; wr_ena = ena;
        if (idx < 4) begin
            mdl_num[idx[1:0]] = num;
            mdl_en[idx[1:0]]  = ena;
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] proto, input logic [15:0] dst, input logic [15:0] ulen,
                            input logic [15:0] iplen, input int nbeats, input int max_gap, input int rst_at);
        int          v, idx, nb;
        logic [31:0] usr;
        logic [7:0]  ff;
        logic [7:0]  k;
        logic        dropped;
        v = model_eval(proto, ulen, iplen, dst, idx);
        case (v)
            0: m_ok++;
            1: m_proto++;
            2: m_len++;
            default: m_port++;
        endcase
        usr = {idx[7:0], 8'h00, ulen - 16'd8};
        dropped = (v != 0);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = {16'($urandom), dst, ulen, 16'($urandom)};
        in_user  = {iplen, 3'($urandom), proto, 29'($urandom)};
        in_keep  = 8'($urandom);
        in_last  = (nbeats == 0);
        wr_en = hw_en; wr_idx = hw_idx; wr_num = hw_num; wr_ena = hw_ena;
        if (hw_en && hw_idx < 4) begin
            mdl_num[hw_idx[1:0]] = hw_num;
            mdl_en[hw_idx[1:0]]  = hw_ena;
        end
        hw_en = 1'b0;
        for (int j = 0; j < nbeats; j++) begin
            for (int g = $urandom_range(0, max_gap); g > 0; g--) begin
                @(negedge clk);
                wr_en = 1'b0; in_valid = 1'b0; in_last = 1'($urandom);
                in_data = {$urandom, $urandom};
            end
            @(negedge clk);
            wr_en   = 1'b0;
            in_valid = 1'b1;
            in_data = {$urandom, $urandom};
            in_last = (j == nbeats - 1);
            nb = int'(ulen) - 8 - 8 * (nbeats - 1);
            ff = 8'hFF;
            k  = (in_last && nb >= 1 && nb <= 8) ? (ff << (8 - nb)) : 8'($urandom);
            in_keep = k;
            if (j == rst_at) begin
                #1 rst_n = 1'b0;
                model_reset();
                dropped = 1'b1;
            end else if (j == rst_at + 1) begin
                #1 rst_n = 1'b1;
            end
            if (!dropped)
                exp_q.push_back('{cyc + 2, in_data, in_last ? k : 8'hFF, in_last, usr});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0; wr_en = 1'b0; in_last = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        idle(2);
        checks++;
        if (m_valid !== 1'b0 || m_data !== '0 || m_user !== '0 || m_last !== 1'b0 || m_keep !== 8'hFF) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b d=%h u=%h l=%b k=%h, want 0/0/0/0/ff", m_valid, m_data, m_user, m_last, m_keep);
        end
        checks++;
        if (cnt_ok !== 0 || cnt_proto !== 0 || cnt_port !== 0 || cnt_len !== 0) begin
            errors++;
            $display("FAIL reset_counters: got %0d %0d %0d %0d, want all 0", cnt_ok, cnt_proto, cnt_port, cnt_len);
        end
        #1 rst_n = 1'b1;
        mon_en = 1'b1;
        idle(2);
    endtask

    task automatic test_basic();
        int unsigned b0;
        b0 = out_beats;
        send_pkt(8'd17, 16'h0808, 16'd28, 16'd28, 3, 0, -1);
        idle(4);
        checks++;
        if (out_beats - b0 !== 3) begin
            errors++; $display("FAIL basic_beats: got %0d, want 3", out_beats - b0);
        end
        checks++;
        if (mon_last_user !== 32'h0000_0014) begin
            errors++; $display("FAIL basic_user: got %h, want 00000014", mon_last_user);
        end
        checks++;
        if (cnt_ok !== 1) begin
            errors++; $display("FAIL basic_cnt_ok: got %0d, want 1", cnt_ok);
        end
    endtask

    task automatic test_port_prog();
        int unsigned b0;
        write_entry(4'd2, 16'h1234, 1'b1);
        send_pkt(8'd17, 16'h1234, 16'd24, 16'd24, 2, 1, -1);
        idle(4);
        checks++;
        if (mon_last_user !== 32'h0200_0010) begin
            errors++; $display("FAIL prog_idx2_user: got %h, want 02000010", mon_last_user);
        end
        b0 = out_beats;
        send_pkt(8'd17, 16'h5555, 16'd24, 16'd24, 2, 0, -1);
        idle(4);
        checks++;
        if (out_beats !== b0 || cnt_port !== 1) begin
            errors++; $display("FAIL prog_miss: got beats=%0d port=%0d, want beats=%0d port=1", out_beats - b0, cnt_port, 0);
        end
        write_entry(4'd1, 16'h1234, 1'b1);
        send_pkt(8'd17, 16'h1234, 16'd9, 16'd9, 1, 0, -1);
        idle(4);
        checks++;
        if (mon_last_user !== 32'h0100_0001) begin
            errors++; $display("FAIL prog_lowest_idx: got %h, want 01000001", mon_last_user);
        end
        write_entry(4'd5, 16'h9999, 1'b1);
        send_pkt(8'd17, 16'h9999, 16'd16, 16'd16, 1, 0, -1);
        hw_en = 1'b1; hw_idx = 4'd3; hw_num = 16'h7777; hw_ena = 1'b1;
        send_pkt(8'd17, 16'h7777, 16'd16, 16'd16, 1, 0, -1);
        send_pkt(8'd17, 16'h7777, 16'd16, 16'd16, 1, 0, -1);
        idle(4);
        checks++;
        if (cnt_port !== 3 || cnt_port !== m_port) begin
            errors++; $display("FAIL prog_oor_and_coincident: got port=%0d, want 3", cnt_port);
        end
        checks++;
        if (mon_last_user !== 32'h0300_0008 || cnt_ok !== m_ok) begin
            errors++; $display("FAIL prog_after_write: got user=%h ok=%0d, want 03000008 ok=%0d", mon_last_user, cnt_ok, m_ok);
        end
    endtask

    task automatic test_drops();
        int unsigned b0, p0, l0;
        b0 = out_beats; p0 = cnt_proto; l0 = cnt_len;
        send_pkt(8'd6, 16'h0808, 16'd24, 16'd24, 2, 1, -1);
        idle(3);
        checks++;
        if (cnt_proto !== p0 + 1) begin
            errors++; $display("FAIL drop_proto: got %0d, want %0d", cnt_proto, p0 + 1);
        end
        send_pkt(8'd17, 16'h0808, 16'd40, 16'd48, 4, 1, -1);
        send_pkt(8'd17, 16'h0808, 16'd4, 16'd4, 1, 0, -1);
        idle(3);
        checks++;
        if (cnt_len !== l0 + 2 || out_beats !== b0) begin
            errors++; $display("FAIL drop_len: got len=%0d beats=%0d, want len=%0d beats=0", cnt_len, out_beats - b0, l0 + 2);
        end
    endtask

    task automatic test_hdr_last();
        int unsigned b0;
        b0 = out_beats;
        send_pkt(8'd17, 16'h0808, 16'd8, 16'd8, 0, 0, -1);
        send_pkt(8'd17, 16'h4321, 16'd8, 16'd8, 0, 0, -1);
        send_pkt(8'd17, 16'h0808, 16'd16, 16'd16, 1, 0, -1);
        idle(4);
        checks++;
        if (out_beats - b0 !== 1 || cnt_ok !== m_ok || cnt_port !== m_port) begin
            errors++; $display("FAIL hdr_last: got beats=%0d ok=%0d port=%0d, want 1 %0d %0d", out_beats - b0, cnt_ok, cnt_port, m_ok, m_port);
        end
    endtask

    task automatic test_back_to_back();
        int unsigned b0;
        b0 = out_beats;
        send_pkt(8'd17, 16'h0808, 16'd45, 16'd45, 5, 2, -1);
        send_pkt(8'd17, 16'h1234, 16'd30, 16'd30, 3, 2, -1);
        idle(4);
        checks++;
        if (out_beats - b0 !== 8) begin
            errors++; $display("FAIL back_to_back: got %0d beats, want 8", out_beats - b0);
        end
    endtask

    task automatic test_random();
        logic [15:0] dsts [4];
        logic [7:0]  proto;
        logic [15:0] ulen, iplen, dst;
        int          r, nbeats;
        dsts[0] = 16'h0808; dsts[1] = 16'h1234; dsts[2] = 16'h7777; dsts[3] = 16'h5555;
        for (int p = 0; p < 40; p++) begin
            r = $urandom_range(0, 9);
            proto = (r == 0) ? 8'd6 : 8'd17;
            ulen  = 16'($urandom_range(0, 30) + 8);
            iplen = (r == 1) ? ulen + 16'd1 : ulen;
            if (r == 2) begin
                ulen = 16'($urandom_range(0, 7)); iplen = ulen;
            end
            dst = dsts[$urandom_range(0, 3)];
            nbeats = (ulen >= 8) ? (int'(ulen) - 8 + 7) / 8 : $urandom_range(0, 2);
            send_pkt(proto, dst, ulen, iplen, nbeats, $urandom_range(0, 2), -1);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(4);
        checks++;
        if (cnt_ok !== m_ok || cnt_proto !== m_proto || cnt_port !== m_port || cnt_len !== m_len) begin
            errors++; $display("FAIL random_counters: got %0d %0d %0d %0d, want %0d %0d %0d %0d",
                               cnt_ok, cnt_proto, cnt_port, cnt_len, m_ok, m_proto, m_port, m_len);
        end
        checks++;
        if (sat_ok !== sat4(m_ok) || sat_proto !== sat4(m_proto) || sat_port !== sat4(m_port) || sat_len !== sat4(m_len)) begin
            errors++; $display("FAIL random_sat_counters: got %0d %0d %0d %0d, want %0d %0d %0d %0d",
                               sat_ok, sat_proto, sat_port, sat_len, sat4(m_ok), sat4(m_proto), sat4(m_port), sat4(m_len));
        end
    endtask

    task automatic test_reset_mid();
        int unsigned b0;
        send_pkt(8'd17, 16'h0808, 16'd56, 16'd56, 6, 0, 1);
        b0 = out_beats;
        send_pkt(8'd17, 16'h0808, 16'd20, 16'd20, 2, 1, -1);
        idle(4);
        checks++;
        if (out_beats - b0 !== 2 || cnt_ok !== 1 || cnt_port !== 0) begin
            errors++; $display("FAIL reset_mid: got beats=%0d ok=%0d port=%0d, want 2 1 0", out_beats - b0, cnt_ok, cnt_port);
        end
    endtask

    task automatic test_saturation();
        for (int p = 0; p < 16; p++)
            send_pkt(8'd17, 16'h0808, 16'd12, 16'd12, 1, 0, -1);
        idle(4);
        checks++;
        if (sat_ok !== 4'hF) begin
            errors++; $display("FAIL sat_ok: got %h, want f", sat_ok);
        end
        checks++;
        if (cnt_ok !== 17) begin
            errors++; $display("FAIL wide_ok_after_sat: got %0d, want 17", cnt_ok);
        end
        send_pkt(8'd17, 16'h0808, 16'd12, 16'd12, 1, 0, -1);
        idle(3);
        checks++;
        if (sat_ok !== 4'hF || sat_port !== 4'h0) begin
            errors++; $display("FAIL sat_hold: got ok=%h port=%h, want f 0", sat_ok, sat_port);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_port_prog();
        test_drops();
        test_hdr_last();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_saturation();
        idle(2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL pending_beats: got %0d left, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, want completion");
        $fatal(1, "timeout");
    end

endmodule
